// File: rtl/backlight_frame_scheduler_if.sv
// Pixel-side and duty-side signals of the backlight frame scheduler.
// The master drives pixels/controls; the slave (scheduler) drives duty and frame stats.
interface backlight_frame_scheduler_if;
  logic        de;
  logic        vsync;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        mode_auto;
  logic [3:0]  manual_duty;
  logic [9:0]  pwm_value;
  logic        pwm_update;
  logic [7:0]  frame_peak;
  logic [15:0] frame_count;

  modport master (
    output de, vsync, r, g, b, mode_auto, manual_duty,
    input  pwm_value, pwm_update, frame_peak, frame_count
  );

  modport slave (
    input  de, vsync, r, g, b, mode_auto, manual_duty,
    output pwm_value, pwm_update, frame_peak, frame_count
  );
endinterface

// File: rtl/backlight_frame_scheduler.sv
// Per-frame backlight duty scheduler: tracks the frame peak of max(R,G,B) and reloads the PWM
// duty once per frame. Define BL_RAMP_EN to slew pwm_value by at most RAMP_STEP per frame.
module backlight_frame_scheduler #(
  parameter bit         VSYNC_POL = 1'b1,
  parameter logic [9:0] MIN_DUTY  = 10'd64,
  parameter logic [9:0] RAMP_STEP = 10'd32
) (
  input logic                          clk,
  input logic                          reset,
  backlight_frame_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {StWait, StAccum, StCalc, StApply} state_e;

  state_e      state_q, state_d;
  logic        vsync_q;
  logic [7:0]  peak_q, peak_d;
  logic [7:0]  frame_peak_q, frame_peak_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [9:0]  target_q, target_d;
  logic [9:0]  pwm_value_q, pwm_value_d;
  logic        pwm_update_q, pwm_update_d;

  logic [7:0]  pix;
  logic [7:0]  rg_max;
  logic        lead;
  logic [9:0]  exp_duty;
  logic [9:0]  duty_next;

  always_comb begin
    rg_max = (bus.r > bus.g) ? bus.r : bus.g;
    pix    = (rg_max > bus.b) ? rg_max : bus.b;
  end

  assign lead     = (bus.vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
  // Replicate the top bits so a full-scale peak maps to full-scale duty.
  assign exp_duty = {frame_peak_q, frame_peak_q[7:6]};

`ifdef BL_RAMP_EN
  logic [10:0] duty_diff;
  logic [10:0] duty_step;
  logic [10:0] duty_sum;

  always_comb begin
    duty_diff = 11'd0;
    duty_step = 11'd0;
    duty_sum  = {1'b0, pwm_value_q};
    if (target_q > pwm_value_q) begin
      duty_diff = {1'b0, target_q} - {1'b0, pwm_value_q};
      duty_step = (duty_diff > {1'b0, RAMP_STEP}) ? {1'b0, RAMP_STEP} : duty_diff;
      duty_sum  = {1'b0, pwm_value_q} + duty_step;
    end else if (target_q < pwm_value_q) begin
      duty_diff = {1'b0, pwm_value_q} - {1'b0, target_q};
      duty_step = (duty_diff > {1'b0, RAMP_STEP}) ? {1'b0, RAMP_STEP} : duty_diff;
      duty_sum  = {1'b0, pwm_value_q} - duty_step;
    end
    duty_next = duty_sum[9:0];
  end
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
  assign duty_next        = target_q;
`endif

  always_comb begin
    state_d       = state_q;
    peak_d        = peak_q;
    frame_peak_d  = frame_peak_q;
    frame_count_d = frame_count_q;
    target_d      = target_q;
    pwm_value_d   = pwm_value_q;
    pwm_update_d  = 1'b0;

    if (state_q != StWait && bus.de && pix > peak_q) begin
      peak_d = pix;
    end

    unique case (state_q)
      StWait: begin
        // The first frame after reset is partial, so it only arms accumulation.
        if (lead) begin
          peak_d  = 8'd0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (lead) begin
          frame_peak_d  = (bus.de && pix > peak_q) ? pix : peak_q;
          peak_d        = 8'd0;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = StCalc;
        end
      end
      StCalc: begin
        if (bus.mode_auto) begin
          target_d = (exp_duty > MIN_DUTY) ? exp_duty : MIN_DUTY;
        end else begin
          target_d = {bus.manual_duty, 6'h3F};
        end
        state_d = StApply;
      end
      StApply: begin
        pwm_value_d  = duty_next;
        pwm_update_d = 1'b1;
        state_d      = StAccum;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWait;
      vsync_q       <= ~VSYNC_POL;
      peak_q        <= 8'd0;
      frame_peak_q  <= 8'd0;
      frame_count_q <= 16'd0;
      target_q      <= 10'h3FF;
      pwm_value_q   <= 10'h3FF;
      pwm_update_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= bus.vsync;
      peak_q        <= peak_d;
      frame_peak_q  <= frame_peak_d;
      frame_count_q <= frame_count_d;
      target_q      <= target_d;
      pwm_value_q   <= pwm_value_d;
      pwm_update_q  <= pwm_update_d;
    end
  end

  assign bus.pwm_value   = pwm_value_q;
  assign bus.pwm_update  = pwm_update_q;
  assign bus.frame_peak  = frame_peak_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_backlight_frame_scheduler.sv
// Directed bench for backlight_frame_scheduler (default build: duty loads the target directly).
module tb_backlight_frame_scheduler;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  backlight_frame_scheduler_if bus ();

  backlight_frame_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb,
                       input logic pde);
    bus.r  = pr;
    bus.g  = pg;
    bus.b  = pb;
    bus.de = pde;
    tick();
  endtask

  // Raise vsync with whatever pixel is currently driven, then follow the frame-end pipeline.
  task automatic lead_frame(input string tag, input logic strobe, input logic [7:0] exp_peak,
                            input logic [15:0] exp_count, input logic [9:0] exp_pwm);
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    bus.de    = 1'b0;
    bus.r     = 8'd0;
    bus.g     = 8'd0;
    bus.b     = 8'd0;
    check({tag, ".peak"}, {24'd0, bus.frame_peak}, {24'd0, exp_peak});
    check({tag, ".count"}, {16'd0, bus.frame_count}, {16'd0, exp_count});
    tick();
    check({tag, ".upd_t2"}, {31'd0, bus.pwm_update}, 32'd0);
    tick();
    check({tag, ".upd_t3"}, {31'd0, bus.pwm_update}, {31'd0, strobe});
    check({tag, ".pwm"}, {22'd0, bus.pwm_value}, {22'd0, exp_pwm});
    tick();
    check({tag, ".upd_t4"}, {31'd0, bus.pwm_update}, 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    bus.de          = 1'b0;
    bus.vsync       = 1'b0;
    bus.r           = 8'd0;
    bus.g           = 8'd0;
    bus.b           = 8'd0;
    bus.mode_auto   = 1'b1;
    bus.manual_duty = 4'h0;
    tick();
    tick();
    check("rst.pwm", {22'd0, bus.pwm_value}, 32'h3FF);
    check("rst.upd", {31'd0, bus.pwm_update}, 32'd0);
    check("rst.peak", {24'd0, bus.frame_peak}, 32'd0);
    check("rst.count", {16'd0, bus.frame_count}, 32'd0);
    reset = 1'b0;

    // Partial first frame: lead only arms accumulation.
    for (int i = 0; i < 4; i++) pixel(8'hFF, 8'hFF, 8'hFF, 1'b1);
    lead_frame("f0", 1'b0, 8'h00, 16'd0, 10'h3FF);

    for (int i = 0; i < 8; i++) pixel(8'hFF, 8'hFF, 8'hFF, 1'b1);
    lead_frame("f1", 1'b1, 8'hFF, 16'd1, 10'h3FF);

    // Single mid-level red pixel: {80, 2'b10} = 0x202.
    for (int i = 0; i < 3; i++) pixel(8'h00, 8'h00, 8'h00, 1'b1);
    pixel(8'h80, 8'h00, 8'h00, 1'b1);
    pixel(8'hF0, 8'hF0, 8'hF0, 1'b0);
    for (int i = 0; i < 3; i++) pixel(8'h00, 8'h00, 8'h00, 1'b1);
    lead_frame("f2", 1'b1, 8'h80, 16'd2, 10'h202);

    // All black: duty floors at MIN_DUTY.
    for (int i = 0; i < 6; i++) pixel(8'h00, 8'h00, 8'h00, 1'b1);
    lead_frame("f3", 1'b1, 8'h00, 16'd3, 10'd64);

    // Manual mode selected mid-frame; duty holds until the next strobe.
    pixel(8'h00, 8'h40, 8'h00, 1'b1);
    bus.mode_auto   = 1'b0;
    bus.manual_duty = 4'hA;
    pixel(8'h00, 8'h00, 8'h00, 1'b1);
    bus.manual_duty = 4'h5;
    pixel(8'h00, 8'h00, 8'h00, 1'b1);
    check("f4.hold", {22'd0, bus.pwm_value}, 32'd64);
    check("f4.noupd", {31'd0, bus.pwm_update}, 32'd0);
    lead_frame("f4", 1'b1, 8'h40, 16'd4, 10'h17F);

    // Pixel coincident with lead belongs to the closing frame.
    bus.mode_auto = 1'b1;
    for (int i = 0; i < 3; i++) pixel(8'h10, 8'h00, 8'h00, 1'b1);
    bus.r  = 8'hC0;
    bus.g  = 8'h00;
    bus.b  = 8'h00;
    bus.de = 1'b1;
    lead_frame("f5", 1'b1, 8'hC0, 16'd5, 10'h303);

    // Next frame restarts from zero: {20, 2'b00} = 0x080.
    for (int i = 0; i < 3; i++) pixel(8'h00, 8'h00, 8'h20, 1'b1);
    lead_frame("f6", 1'b1, 8'h20, 16'd6, 10'h080);

    // Reset pulsed mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) pixel(8'hFF, 8'hFF, 8'hFF, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst.pwm", {22'd0, bus.pwm_value}, 32'h3FF);
    check("mrst.count", {16'd0, bus.frame_count}, 32'd0);
    check("mrst.peak", {24'd0, bus.frame_peak}, 32'd0);
    for (int i = 0; i < 3; i++) pixel(8'hFF, 8'hFF, 8'hFF, 1'b1);
    lead_frame("f7", 1'b0, 8'h00, 16'd0, 10'h3FF);
    for (int i = 0; i < 3; i++) pixel(8'h00, 8'h80, 8'h00, 1'b1);
    lead_frame("f8", 1'b1, 8'h80, 16'd1, 10'h202);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
